// File: rtl/alu_sequencer.sv
// Command front-end for the ALU: buffers commands in a FIFO, issues them one at a time,
// captures the registered ALU result and returns it with the command tag.
module alu_sequencer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [7:0]       cmd_a,
   input  logic [7:0]       cmd_b,
   input  logic [3:0]       cmd_op,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [3:0]       alu_op,
   input  logic [7:0]       alu_result,
   input  logic             alu_carry,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_result,
   output logic             rsp_carry,
   output logic             rsp_err,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef struct packed {
      logic [7:0]       a;
      logic [7:0]       b;
      logic [3:0]       op;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_t;

   cmd_t             r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   state_t           r_state;
   state_t           w_state_next;

   logic [7:0]       r_alu_a;
   logic [7:0]       r_alu_b;
   logic [3:0]       r_alu_op;
   logic [7:0]       r_rsp_result;
   logic             r_rsp_carry;
   logic             r_rsp_err;
   logic [TAG_W-1:0] r_rsp_tag;

   logic             w_push;
   logic             w_pop;
   logic             w_legal;
   cmd_t             w_head;

   // ------------------------------------------------------------------
   // Command FIFO
   // ------------------------------------------------------------------
   assign cmd_ready = (r_count != FULL_CNT);
   assign w_push    = cmd_valid && cmd_ready;
   assign w_pop     = (r_state == StIdle) && (r_count != '0);
   assign w_head    = r_mem[r_rd_ptr];

   // Illegal opcodes and divide-by-zero are answered locally and never reach the ALU
   assign w_legal = (w_head.op <= 4'd3) && !((w_head.op == 4'd3) && (w_head.b == 8'd0));

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Sequencing FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_pop) begin
               w_state_next = w_legal ? StIssue : StResp;
            end
         end
         StIssue:   w_state_next = StCapture;
         StCapture: w_state_next = StResp;
         StResp: begin
            if (rsp_ready) begin
               w_state_next = StIdle;
            end
         end
         default:   w_state_next = StIdle;
      endcase
   end

   always_comb begin
      rsp_valid = (r_state == StResp);
      busy      = (r_state != StIdle) || (r_count != '0);
   end

   // ------------------------------------------------------------------
   // ALU operand and response registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_op     <= '0;
         r_rsp_result <= '0;
         r_rsp_carry  <= 1'b0;
         r_rsp_err    <= 1'b0;
         r_rsp_tag    <= '0;
      end else begin
         if (w_pop) begin
            r_rsp_tag <= w_head.tag;
            if (w_legal) begin
               r_alu_a  <= w_head.a;
               r_alu_b  <= w_head.b;
               r_alu_op <= w_head.op;
            end else begin
               r_rsp_result <= '0;
               r_rsp_carry  <= 1'b0;
               r_rsp_err    <= 1'b1;
            end
         end
         if (r_state == StCapture) begin
            r_rsp_result <= alu_result;
            r_rsp_carry  <= alu_carry;
            r_rsp_err    <= 1'b0;
         end
      end
   end

   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_op     = r_alu_op;
   assign rsp_result = r_rsp_result;
   assign rsp_carry  = r_rsp_carry;
   assign rsp_err    = r_rsp_err;
   assign rsp_tag    = r_rsp_tag;

endmodule
